result_serializer: RTL and testbench
====================================

Name: result_serializer

Overview:
- Downstream stage of the encrypter bank. Collects encrypted packets from NUM_ENCRYPTERS encrypters in strict round-robin order (0,1,…,N-1,0,…), which is the order the upstream parallelizer dispatches them.
- Shifts each packet out as 4-bit nibbles on a QSPI-style output, MSB nibble first, so the host receives ciphertext in the same order it sent plaintext.

Parameters:
- NUM_ENCRYPTERS, 4, number of encrypter lanes.
- ENCRYPTER_WIDTH, 32, bits per packet; must be a multiple of 4.
- NIBBLES, ENCRYPTER_WIDTH/4, derived: nibbles per packet.
- CNT_WIDTH, 16, width of the packets_sent counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous abort; restarts the lane order at 0 (upstream raises it at stream start).
- enc_data  in  NUM_ENCRYPTERS*ENCRYPTER_WIDTH  flattened result buses; lane i occupies bits [i*W +: W].
- enc_valid  in  NUM_ENCRYPTERS  lane i holds a finished result; held high until acked.
- enc_ack  out  NUM_ENCRYPTERS  one-cycle pulse; lane i's result was captured.
- qspi_out_data  out  4  current nibble.
- qspi_out_valid  out  1  qspi_out_data is valid.
- qspi_out_ready  in  1  host accepts the nibble at this posedge.
- lane_ptr  out  clog2(NUM_ENCRYPTERS)  lane expected next.
- busy  out  1  high while a packet is being shifted out.
- packets_sent  out  CNT_WIDTH  completed packets, wraps modulo 2^CNT_WIDTH.

Behaviour:
- All outputs are registered. Reset values: enc_ack=0, qspi_out_data=0, qspi_out_valid=0, lane_ptr=0, busy=0, packets_sent=0, state=S_WAIT.
- Priority: reset > flush > normal operation.
- S_WAIT: sample enc_valid[lane_ptr] only; valids on other lanes are ignored until their turn, with no reordering.
  - If it is set at edge k: capture the slice into shift_reg, set enc_ack[lane_ptr]=1 for the single cycle k+1, set nib_cnt=NIBBLES-1, and go to S_SHIFT.
  - In cycle k+1: qspi_out_valid=1, busy=1, qspi_out_data=shift_reg[W-1:W-4].
- S_SHIFT: a transfer occurs at a posedge with qspi_out_valid && qspi_out_ready.
  - On a transfer with nib_cnt>0: shift_reg shifts left 4, nib_cnt decrements, and the next nibble appears the following cycle.
  - On a transfer with nib_cnt==0: qspi_out_valid=0, busy=0, lane_ptr increments (NUM_ENCRYPTERS-1 wraps to 0), packets_sent increments, state=S_WAIT.
  - With qspi_out_ready low: data and valid are held stable indefinitely (backpressure).
- Latency and throughput:
  - First nibble is valid 1 cycle after enc_valid is sampled.
  - Best-case throughput is NIBBLES+1 cycles per packet, including one S_WAIT bubble.
- The encrypter must drop enc_valid on the cycle after enc_ack. Because enc_valid is not re-sampled in S_SHIFT, a late drop causes no double capture. A still-high valid on the same lane one full round later is treated as a new result.
- flush in any state: state=S_WAIT, lane_ptr=0, qspi_out_valid=0, busy=0, enc_ack=0, and the partial packet is discarded. packets_sent is unchanged.
- Reset mid-packet: same as flush, and in addition packets_sent=0.
- Simultaneous flush and enc_valid[0] in S_WAIT: flush wins and no capture happens that cycle. The lane is captured on the next cycle if valid is still high.

Decomposition:
- Shared constants package (alongside the existing constants header): ENCRYPTER_WIDTH, NUM_ENCRYPTERS, NIBBLES, state encodings S_WAIT=1'b0 and S_SHIFT=1'b1.
- One natural sub-module, nibble_shifter: load, shift-on-transfer, nib_cnt, and last flag. The top level keeps the round-robin pointer, ack generation, and counter.

Test Plan:
- Basic: N=4, W=32; lane 0 valid with 0xDEADBEEF, ready held high → ack[0] pulses 1 cycle; nibbles D,E,A,D,B,E,E,F on 8 consecutive cycles; lane_ptr=1; packets_sent=1.
- Ordering: lanes 3,1,0,2 raise valid in that order with 0x33333333, 0x11111111, 0x00000000, 0x22222222 → output order lane 0,1,2,3; no ack to lane 3 before the lane 2 packet completes.
- Backpressure: lane 0 valid 0x12345678; ready low for 5 cycles after the first nibble, then toggling 1/0 → exactly 8 transfers 1..8 in order; data stable while ready is low.
- Wrap: 6 packets, all lanes valid, ready high → lane sequence 0,1,2,3,0,1; packets_sent=6; lane_ptr=2; each packet takes 9 cycles.
- Flush mid-packet: flush after 3 nibbles of lane 1's packet → valid drops next cycle, lane_ptr=0, packets_sent unchanged; next packet comes from lane 0.
- Reset mid-packet: reset during shift → all outputs at reset values the next cycle; flush and enc_valid[0] asserted together → no ack that cycle, ack the cycle after.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// Shared constants and state encoding for the encrypter-bank result serializer.
package result_serializer_pkg;

  localparam int NUM_ENCRYPTERS  = 4;
  localparam int ENCRYPTER_WIDTH = 32;
  localparam int NIBBLES         = ENCRYPTER_WIDTH / 4;
  localparam int CNT_WIDTH       = 16;

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Pointer/counter width that never collapses to zero bits.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_serializer_nibble_shifter.sv
// Holds one captured packet and presents it MSB nibble first, advancing one
// nibble per accepted transfer; last flags the final nibble of the packet.
module result_serializer_nibble_shifter
  import result_serializer_pkg::*;
#(
  parameter int WIDTH = result_serializer_pkg::ENCRYPTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             advance,
  output logic [3:0]       nibble,
  output logic             last
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = ptr_width(NIB);

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    nib_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg <= '0;
      nib_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      nib_cnt   <= CW'(NIB - 1);
    end else if (advance && !last) begin
      shift_reg <= {shift_reg[WIDTH-5:0], 4'h0};
      nib_cnt   <= nib_cnt - 1'b1;
    end
  end

  assign nibble = shift_reg[WIDTH-1 -: 4];
  assign last   = (nib_cnt == '0);

endmodule

// File: rtl/result_serializer.sv
// Round-robin collector for the encrypter bank: takes lanes strictly in order
// and streams each packet out as nibbles with valid/ready backpressure.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int NUM_ENCRYPTERS  = result_serializer_pkg::NUM_ENCRYPTERS,
  parameter int ENCRYPTER_WIDTH = result_serializer_pkg::ENCRYPTER_WIDTH,
  parameter int CNT_WIDTH       = result_serializer_pkg::CNT_WIDTH,
  localparam int PTR_W          = ptr_width(NUM_ENCRYPTERS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_data,
  input  logic [NUM_ENCRYPTERS-1:0]                 enc_valid,
  output logic [NUM_ENCRYPTERS-1:0]                 enc_ack,
  output logic [3:0]                                qspi_out_data,
  output logic                                      qspi_out_valid,
  input  logic                                      qspi_out_ready,
  output logic [PTR_W-1:0]                          lane_ptr,
  output logic                                      busy,
  output logic [CNT_WIDTH-1:0]                      packets_sent
);

  localparam int W = ENCRYPTER_WIDTH;

  state_t         state;
  logic [W-1:0]   lane_slice;
  logic           load;
  logic           advance;
  logic           last;

  // Only the lane whose turn it is can be captured; others wait, never reorder.
  assign lane_slice = enc_data[int'(lane_ptr)*W +: W];
  assign load       = (state == S_WAIT) && enc_valid[lane_ptr] && !flush;
  assign advance    = (state == S_SHIFT) && qspi_out_valid && qspi_out_ready && !flush;

  result_serializer_nibble_shifter #(
    .WIDTH(W)
  ) u_nibble_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (load),
    .load_data(lane_slice),
    .advance  (advance),
    .nibble   (qspi_out_data),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_WAIT;
      enc_ack        <= '0;
      qspi_out_valid <= 1'b0;
      busy           <= 1'b0;
      lane_ptr       <= '0;
      packets_sent   <= '0;
    end else if (flush) begin
      state          <= S_WAIT;
      enc_ack        <= '0;
      qspi_out_valid <= 1'b0;
      busy           <= 1'b0;
      lane_ptr       <= '0;
    end else begin
      enc_ack <= '0;
      case (state)
        S_WAIT: begin
          if (load) begin
            enc_ack        <= NUM_ENCRYPTERS'(1) << lane_ptr;
            qspi_out_valid <= 1'b1;
            busy           <= 1'b1;
            state          <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (advance && last) begin
            qspi_out_valid <= 1'b0;
            busy           <= 1'b0;
            lane_ptr       <= (lane_ptr == PTR_W'(NUM_ENCRYPTERS - 1)) ? '0 : lane_ptr + 1'b1;
            packets_sent   <= packets_sent + 1'b1;
            state          <= S_WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench: expected acks/nibbles are queued as stimulus is planned
// and consumed as the serializer acks lanes and transfers nibbles.
module tb_result_serializer;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic [N*W-1:0] enc_data;
  logic [N-1:0]   enc_valid;
  logic [N-1:0]   enc_ack;
  logic [3:0]     qspi_out_data;
  logic           qspi_out_valid;
  logic           qspi_out_ready;
  logic [1:0]     lane_ptr;
  logic           busy;
  logic [15:0]    packets_sent;

  always #5 clk = ~clk;

  result_serializer #(
    .NUM_ENCRYPTERS (N),
    .ENCRYPTER_WIDTH(W),
    .CNT_WIDTH      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .enc_data      (enc_data),
    .enc_valid     (enc_valid),
    .enc_ack       (enc_ack),
    .qspi_out_data (qspi_out_data),
    .qspi_out_valid(qspi_out_valid),
    .qspi_out_ready(qspi_out_ready),
    .lane_ptr      (lane_ptr),
    .busy          (busy),
    .packets_sent  (packets_sent)
  );

  // Encrypter model: per-lane result FIFO, valid while requests outstanding.
  logic [W-1:0] lane_data [N][8];
  logic [2:0]   req_cnt   [N];
  logic [2:0]   done_cnt  [N];

  always_comb begin
    enc_valid = '0;
    enc_data  = '0;
    for (int i = 0; i < N; i++) begin
      enc_valid[i]       = (req_cnt[i] != done_cnt[i]);
      enc_data[i*W +: W] = lane_data[i][done_cnt[i]];
    end
  end

  logic [3:0] exp_nib[$];
  int         exp_ack[$];
  int         n_chk, n_pass, cyc;
  int         ack_cyc, last_ack_cyc, last_xfer_cyc;
  bit         period_chk, prev_ack_any;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Resolve the upcoming posedge from current outputs/inputs, then sample at negedge.
  task automatic tick();
    logic       stall;
    logic [3:0] hold_d;
    stall  = (qspi_out_valid === 1'b1) && !qspi_out_ready && !flush && !reset;
    hold_d = qspi_out_data;
    if ((qspi_out_valid === 1'b1) && qspi_out_ready && !flush && !reset) begin
      if (exp_nib.size() == 0) chk("xfer_unexp", 32'(qspi_out_data), 32'hFF);
      else                     chk("nibble", 32'(qspi_out_data), 32'(exp_nib.pop_front()));
      last_xfer_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
    if (stall) begin
      chk("hold_valid", 32'(qspi_out_valid), 1);
      chk("hold_data", 32'(qspi_out_data), 32'(hold_d));
    end
    for (int i = 0; i < N; i++) begin
      if (enc_ack[i] === 1'b1) begin
        if (exp_ack.size() == 0) chk("ack_unexp", i, 32'hFFFF);
        else                     chk("ack_lane", i, exp_ack.pop_front());
        chk("ack_pulse", 32'(prev_ack_any), 0);
        if (period_chk && last_ack_cyc >= 0) chk("period", cyc - last_ack_cyc, 9);
        last_ack_cyc = cyc;
        ack_cyc      = cyc;
        done_cnt[i]  = done_cnt[i] + 1'b1;
      end
    end
    prev_ack_any = (|enc_ack === 1'b1);
  endtask

  task automatic send(input int lane, input logic [W-1:0] d);
    lane_data[lane][req_cnt[lane]] = d;
    req_cnt[lane] = req_cnt[lane] + 1'b1;
  endtask

  task automatic expect_pkt(input int lane, input logic [W-1:0] d, input int nn);
    exp_ack.push_back(lane);
    for (int k = 0; k < nn; k++) exp_nib.push_back(d[W-1-4*k -: 4]);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (exp_nib.size() != 0 || exp_ack.size() != 0); t++) tick();
    chk("drain", exp_nib.size() + exp_ack.size(), 0);
  endtask

  task automatic check_idle(input int ptr, input int pkts);
    chk("lane_ptr", 32'(lane_ptr), ptr);
    chk("packets_sent", 32'(packets_sent), pkts);
    chk("busy_idle", 32'(busy), 0);
    chk("valid_idle", 32'(qspi_out_valid), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_ack", 32'(enc_ack), 0);
    chk("rst_data", 32'(qspi_out_data), 0);
    chk("rst_valid", 32'(qspi_out_valid), 0);
    chk("rst_ptr", 32'(lane_ptr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkts", 32'(packets_sent), 0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    ack_cyc = 0; last_ack_cyc = -1; last_xfer_cyc = 0;
    period_chk = 1'b0; prev_ack_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_cnt[i]  = '0;
      done_cnt[i] = '0;
      for (int s = 0; s < 8; s++) lane_data[i][s] = '0;
    end
    reset = 1'b1; flush = 1'b0; qspi_out_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    reset = 1'b0;
    qspi_out_ready = 1'b1;

    // Basic single packet, ready always high.
    expect_pkt(0, 32'hDEADBEEF, 8);
    send(0, 32'hDEADBEEF);
    drain();
    chk("basic_span", last_xfer_cyc - ack_cyc, 7);
    check_idle(1, 1);

    // Lanes raise valid out of order; output must follow 0,1,2,3.
    pulse_flush();
    chk("flush_ptr", 32'(lane_ptr), 0);
    chk("flush_pkts", 32'(packets_sent), 1);
    expect_pkt(0, 32'h00000000, 8);
    expect_pkt(1, 32'h11111111, 8);
    expect_pkt(2, 32'h22222222, 8);
    expect_pkt(3, 32'h33333333, 8);
    send(3, 32'h33333333); tick();
    send(1, 32'h11111111); tick();
    send(0, 32'h00000000); tick();
    send(2, 32'h22222222);
    drain();
    check_idle(0, 5);

    // Backpressure: hold ready low, then toggle.
    qspi_out_ready = 1'b0;
    expect_pkt(0, 32'h12345678, 8);
    send(0, 32'h12345678);
    for (int t = 0; t < 20 && qspi_out_valid !== 1'b1; t++) tick();
    chk("bp_valid", 32'(qspi_out_valid), 1);
    chk("bp_first", 32'(qspi_out_data), 32'h1);
    repeat (5) tick();
    for (int t = 0; t < 100 && exp_nib.size() != 0; t++) begin
      qspi_out_ready = !qspi_out_ready;
      tick();
    end
    chk("bp_drain", exp_nib.size(), 0);
    qspi_out_ready = 1'b1;
    tick();
    check_idle(1, 6);

    // Six back-to-back packets wrap the lane pointer; 9 cycles each.
    pulse_flush();
    period_chk = 1'b1;
    last_ack_cyc = -1;
    for (int k = 0; k < 6; k++) expect_pkt(k % N, 32'h10203040 + k * 32'h01010101, 8);
    for (int k = 0; k < 6; k++) send(k % N, 32'h10203040 + k * 32'h01010101);
    drain();
    period_chk = 1'b0;
    check_idle(2, 12);

    // Flush after three nibbles of lane 1's packet.
    pulse_flush();
    expect_pkt(0, 32'hCAFEF00D, 8);
    expect_pkt(1, 32'h87654321, 3);
    send(0, 32'hCAFEF00D);
    send(1, 32'h87654321);
    drain();
    pulse_flush();
    check_idle(0, 13);
    expect_pkt(0, 32'h0BADC0DE, 8);
    send(0, 32'h0BADC0DE);
    drain();
    check_idle(1, 14);

    // Reset mid-packet, then flush colliding with lane 0 valid.
    expect_pkt(1, 32'h5A5AC3C3, 2);
    send(1, 32'h5A5AC3C3);
    drain();
    reset = 1'b1;
    tick();
    check_reset_vals();
    reset = 1'b0;
    flush = 1'b1;
    expect_pkt(0, 32'h76543210, 8);
    send(0, 32'h76543210);
    tick();
    chk("flush_noack", 32'(enc_ack), 0);
    flush = 1'b0;
    tick();
    chk("flush_ack_next", 32'(enc_ack), 1);
    drain();
    check_idle(1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
